// File: rtl/snake_scoreboard_7seg_pkg.sv
// Shared constants for the snake score display: segment patterns (active-low a..g),
// digit count and BCD nibble width.
package snake_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

endpackage

// File: rtl/snake_scoreboard_7seg_bcd_to_7seg.sv
// BCD nibble to active-low seven-segment pattern; blank flag forces all segments off.
// Latency: combinational. Backpressure: none.
// Non-BCD nibbles (A-F) render as a dash so a corrupted score is visible.
module bcd_to_7seg
    import snake_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    input  logic             i_blank,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/snake_scoreboard_7seg.sv
// Four-digit multiplexed score display driver; optional leading-zero blanking via SNAKE_SCOREBOARD_BLANK_EN.
// Latency: a score change shows at its digit's next slot (at most 4*SCAN_DIV cycles); outputs registered.
// Backpressure: none; i_Score is sampled only on scan-tick edges.
module snake_scoreboard_7seg
    import snake_pkg::*;
#(
    parameter int SCORE_WIDTH = 16,
    parameter int SCAN_DIV    = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [SCORE_WIDTH-1:0] i_Score,
    output logic [6:0]             o_ScoreDisplay,
    output logic [NUM_DIGITS-1:0]  o_SegmentSelect
);

    localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [6:0]            seg_q, seg_d;

    logic                  tick;
    logic [1:0]            idx_nxt;
    logic [BCD_W-1:0]      nib;
    logic                  blank;
    logic [6:0]            seg_dec;
    logic [15:0]           score_lo;
    logic                  unused_score;

    // Only the low four BCD digits are displayed; wider score buses are tolerated.
    assign score_lo     = i_Score[15:0];
    assign unused_score = ^i_Score;

    always_comb begin
        tick    = (cnt_q == CNT_MAX);
        idx_nxt = idx_q + 2'd1;
        nib     = score_lo[{idx_nxt, 2'b00} +: BCD_W];
        blank   = 1'b0;
`ifdef SNAKE_SCOREBOARD_BLANK_EN
        // A digit blanks only while it and every more-significant digit are zero.
        case (idx_nxt)
            2'd1:    blank = (score_lo[15:4]  == 12'd0);
            2'd2:    blank = (score_lo[15:8]  == 8'd0);
            2'd3:    blank = (score_lo[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    bcd_to_7seg u_dec (
        .i_bcd   (nib),
        .i_blank (blank),
        .o_seg   (seg_dec)
    );

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        sel_d = sel_q;
        seg_d = seg_q;
        if (tick) begin
            idx_d = idx_nxt;
            sel_d = 4'b0001 << idx_nxt;
            seg_d = seg_dec;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            sel_q <= 4'b0001;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign o_ScoreDisplay  = seg_q;
    assign o_SegmentSelect = sel_q;

endmodule

// File: tb/tb_snake_scoreboard_7seg.sv
// Bench for snake_scoreboard_7seg: one instance at SCAN_DIV=1, one at SCAN_DIV=3 with a wider score bus.
module tb_snake_scoreboard_7seg;

    logic        clk;
    logic        rst;
    logic [15:0] score_a;
    logic [19:0] score_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  sel_a, sel_b;

    int checks   = 0;
    int failures = 0;

    // Expected-state model: edges since reset decide the digit, display latched on ticks.
    int         e_a, e_b;
    logic [3:0] xsel_a, xsel_b;
    logic [6:0] xseg_a, xseg_b;

    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b1111110, 7'b1111110,
        7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110
    };

    logic [3:0] seq_sel [4];
    logic [6:0] seq_seg [4];
    logic [15:0] dir_scores [6];

    snake_scoreboard_7seg #(.SCORE_WIDTH(16), .SCAN_DIV(1)) dut_a (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Score         (score_a),
        .o_ScoreDisplay  (seg_a),
        .o_SegmentSelect (sel_a)
    );

    snake_scoreboard_7seg #(.SCORE_WIDTH(20), .SCAN_DIV(3)) dut_b (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Score         (score_b),
        .o_ScoreDisplay  (seg_b),
        .o_SegmentSelect (sel_b)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [15:0] s, input int pos);
        logic [15:0] upper;
        upper = s >> (4 * pos);
`ifdef SNAKE_SCOREBOARD_BLANK_EN
        if (pos > 0 && upper == 16'd0) return 7'b1111111;
`endif
        return TBL[int'(upper & 16'hF)];
    endfunction

    task automatic model_edge(input int d, input logic r, input logic [15:0] s,
                              inout int e, inout logic [3:0] xs, inout logic [6:0] xg);
        int pos;
        if (r) begin
            e  = 0;
            xs = 4'b0001;
            xg = 7'b1111111;
        end else begin
            e = e + 1;
            if (e % d == 0) begin
                pos = (e / d) % 4;
                xs  = 4'b0001 << pos;
                xg  = ref_seg(s, pos);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(1, rst, score_a,       e_a, xsel_a, xseg_a);
        model_edge(3, rst, score_b[15:0], e_b, xsel_b, xseg_b);
        @(negedge clk);
        chk("a_sel",    32'(sel_a),          32'(xsel_a));
        chk("a_seg",    32'(seg_a),          32'(xseg_a));
        chk("a_onehot", 32'($onehot(sel_a)), 32'd1);
        chk("b_sel",    32'(sel_b),          32'(xsel_b));
        chk("b_seg",    32'(seg_b),          32'(xseg_b));
        chk("b_onehot", 32'($onehot(sel_b)), 32'd1);
    endtask

    function automatic logic [15:0] rand_score();
        logic [15:0] s;
        if ($urandom_range(0, 3) == 0) begin
            s = 16'($urandom);
        end else begin
            for (int k = 0; k < 4; k++) s[4*k +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) s[15:8] = 8'h00;
        end
        return s;
    endfunction

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        score_a = 16'h0000;
        score_b = 20'h00000;
        e_a = 0; e_b = 0;
        xsel_a = 4'b0001; xsel_b = 4'b0001;
        xseg_a = 7'h7F;   xseg_b = 7'h7F;

        seq_sel = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_seg = '{7'b0000110, 7'b0010010, 7'b1001111, 7'b1001100};
        dir_scores = '{16'h9876, 16'h2333, 16'h9898, 16'h0550, 16'h0000, 16'h00A0};

        // Reset held two cycles.
        @(negedge clk);
        step();
        step();
        chk("rst_sel_a", 32'(sel_a), 32'h1);
        chk("rst_seg_a", 32'(seg_a), 32'h7F);
        chk("rst_sel_b", 32'(sel_b), 32'h1);
        chk("rst_seg_b", 32'(seg_b), 32'h7F);

        // Release with 1234: tens first, then hundreds, thousands, ones.
        rst     = 1'b0;
        score_a = 16'h1234;
        score_b = {4'hF, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq1234_sel", 32'(sel_a), 32'(seq_sel[i]));
            chk("seq1234_seg", 32'(seg_a), 32'(seq_seg[i]));
        end
        for (int i = 0; i < 8; i++) step();

        // Directed scores, long enough for the slower instance to cover all digits.
        for (int j = 0; j < 6; j++) begin
            score_a = dir_scores[j];
            score_b = {4'($urandom), dir_scores[j]};
            for (int i = 0; i < 14; i++) begin
                step();
                if (dir_scores[j] == 16'h0550 && xsel_a == 4'b1000) begin
`ifdef SNAKE_SCOREBOARD_BLANK_EN
                    chk("s0550_thou", 32'(seg_a), 32'h7F);
`else
                    chk("s0550_thou", 32'(seg_a), 32'b0000001);
`endif
                end
                if (dir_scores[j] == 16'h0550 && xsel_a == 4'b0100)
                    chk("s0550_hund", 32'(seg_a), 32'b0100100);
                if (dir_scores[j] == 16'h0000 && xsel_a == 4'b0001)
                    chk("s0000_ones", 32'(seg_a), 32'b0000001);
                if (dir_scores[j] == 16'h00A0 && xsel_a == 4'b0010)
                    chk("s00A0_tens", 32'(seg_a), 32'b1111110);
            end
        end

        // Randomized scores with occasional resets landing anywhere in a slot.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                score_a = rand_score();
                score_b = {4'($urandom), score_a};
            end
            rst = ($urandom_range(0, 39) == 0);
            step();
        end

        // Reset asserted mid-slot on the SCAN_DIV=3 instance.
        rst = 1'b0;
        score_a = 16'h4321;
        score_b = {4'h0, 16'h4321};
        for (int i = 0; i < 8 && (e_b % 3) != 1; i++) step();
        chk("midslot_pos", 32'(e_b % 3), 32'd1);
        rst = 1'b1;
        step();
        chk("midslot_sel", 32'(sel_b), 32'h1);
        chk("midslot_seg", 32'(seg_b), 32'h7F);
        rst = 1'b0;

        // Each select value holds exactly three cycles on the slow instance.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk("hold3_sel", 32'(sel_b), 32'(4'b0001 << ((s + ((i == 2) ? 1 : 0)) % 4)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snake_scoreboard_7seg.md
# snake_scoreboard_7seg

Implements `snake_scoreboard`, the four-digit score display driver for the snake game. It takes the game's packed-BCD score and time-multiplexes it onto a shared active-low seven-segment bus with a one-hot digit select. It sits between the score counter and the board's 4-digit common-anode display.

## Interface
- `SCORE_WIDTH`, default 16: width of `i_Score`. Must be ≥16. Only `[15:0]` is displayed; higher bits are ignored.
- `SCAN_DIV`, default 1: clock cycles each digit stays selected. Range 1..2^16.
- `i_Clk`  in  1  system clock; all logic on the rising edge.
- `i_Rst`  in  1  reset, synchronous, active-high.
- `i_Score`  in  SCORE_WIDTH  packed BCD score.
  - `[3:0]` = ones, `[7:4]` = tens, `[11:8]` = hundreds, `[15:12]` = thousands.
- `o_ScoreDisplay`  out  7  segment pattern, active-low (0 = lit).
  - Bit 6 = a, bit 5 = b, … bit 0 = g.
- `o_SegmentSelect`  out  4  one-hot, active-high digit enable. Bit n selects digit n (bit 0 = ones).

## Operation
- Internal 2-bit digit index `idx` and a scan counter `0..SCAN_DIV-1`.
- Scan tick: the scan counter reaches `SCAN_DIV-1`, then wraps to 0. With `SCAN_DIV=1`, every cycle is a tick.
- On each tick:
  - `idx` advances 0→1→2→3→0.
  - `o_SegmentSelect <= 1<<idx_next`.
  - `o_ScoreDisplay <= decode(i_Score[4*idx_next+3 : 4*idx_next])`, sampled at that same edge.
- The select and display registers always update together, so they never disagree.
- Decode table (7-bit active-low, a..g):
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0001100
- Non-BCD nibble (A–F): dash 1111110 (g only lit).
- No decimal point is driven.
- `o_SegmentSelect` is always exactly one-hot after reset; it is never 0 and never multi-hot.

## Timing
- Reset (`i_Rst` high at a rising edge):
  - `idx=0`, scan counter 0.
  - `o_SegmentSelect=4'b0001`, `o_ScoreDisplay=7'b1111111` (blank).
- Reset asserted mid-scan takes effect at the next edge and overrides a tick in the same cycle.
- First tick after reset release: select 0010, display shows the tens digit.
  - With `SCAN_DIV=1`, this is the first edge with `i_Rst` low.
- Latency: a change on `i_Score` appears the next time its digit is selected. Maximum is 4·`SCAN_DIV` cycles.
- `i_Score` is sampled only at tick edges and is not otherwise registered.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SNAKE_SCOREBOARD_BLANK_EN`: leading-zero blanking.
- Defined:
  - Thousands, hundreds and tens digits output 1111111 while they and all higher digits are 0.
  - The ones digit is always shown. Example: score 0050 shows blank, blank, 5, 0.
- Undefined: all four digits are always decoded, including leading zeros.
- Select scanning is identical in both builds.

## Structure
- Shared package `snake_pkg` holds:
  - segment constants `SEG_0`…`SEG_9`, `SEG_BLANK` (1111111) and `SEG_DASH` (1111110);
  - `NUM_DIGITS=4`;
  - the BCD digit width of 4.
- One sub-module, `bcd_to_7seg`: purely combinational.
  - In: 4-bit BCD plus a `blank` flag.
  - Out: 7-bit active-low pattern.
- The top level holds the scan counter, digit index, blanking logic and output registers.

## Test plan
- Reset:
  - Hold `i_Rst` 2 cycles → select 0001, display 1111111.
  - Release → select sequence 0010, 0100, 1000, 0001 on consecutive edges (`SCAN_DIV=1`).
- Score 16'h1234:
  - Over 4 cycles, each select pairs with its digit: 0001→4 (1001100), 0010→3 (0000110), 0100→2 (0010010), 1000→1 (1001111).
- Scores 16'h9876, 16'h2333, 16'h9898:
  - Every digit pairing is correct every cycle.
  - Select is one-hot on every cycle.
- Score 16'h0550:
  - Without the macro: thousands → 0000001.
  - With `SNAKE_SCOREBOARD_BLANK_EN`: thousands → 1111111, hundreds → 0100100, ones → 0000001.
  - Score 16'h0000 with the macro: only the ones digit is lit (0000001).
- Invalid nibble 16'h00A0 → tens digit shows 1111110.
- `SCAN_DIV=3`:
  - Each select value holds exactly 3 cycles.
  - Change `i_Score` mid-slot → the new value appears at that digit's next slot.
  - Reset asserted mid-slot → 0001 / blank the following edge.
